// File: rtl/frame_scanout_reader.sv
// ============================================================================
// frame_scanout_reader
//   Reads an RGB565 frame out of SD_RAM one word at a time.
//   Each word is buffered in a small FIFO, expanded to 8-bit R/G/B,
//   and streamed out with valid/ready flow control.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module frame_scanout_reader #(
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int          ADDR_STEP  = 2,
    parameter int          NUM_PIXELS = 256,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        frame_ready,
    output logic        SD_read,
    output logic [31:0] SD_address,
    input  logic [15:0] SD_rdata,
    input  logic        SD_rvalid,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_last,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam int              CW       = $clog2(NUM_PIXELS);
    localparam int              PW       = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0]   LAST_IDX = CW'(NUM_PIXELS - 1);
    localparam logic [31:0]     STEP     = 32'(ADDR_STEP);
    localparam logic [PW:0]     DEPTH_C  = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state;
    state_t         state_nx;
    logic [CW-1:0]  req_cnt;
    logic [CW-1:0]  out_cnt;
    logic [15:0]    mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [PW:0]    count;
    logic [15:0]    head;
    logic           push;
    logic           pop;
    logic [PW:0]    occ_after_pop;

    assign push          = (state == S_REQ) && SD_rvalid;
    assign pix_valid     = (count != '0);
    assign pop           = pix_valid && pix_ready;
    assign occ_after_pop = count - {{PW{1'b0}}, pop};
    assign head          = mem[rd_ptr];

    // Bit replication so full-scale 5/6-bit codes map to 8'hFF.
    assign pix_r      = {head[15:11], head[15:13]};
    assign pix_g      = {head[10:5],  head[10:9]};
    assign pix_b      = {head[4:0],   head[4:2]};
    assign pix_last   = pix_valid && (out_cnt == LAST_IDX);
    assign SD_read    = (state == S_REQ);
    assign busy       = (state != S_IDLE);
    assign frame_done = (state == S_DONE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (frame_ready) state_nx = S_REQ;
            S_REQ:   if (SD_rvalid) state_nx = (req_cnt == LAST_IDX) ? S_DRAIN : S_WAIT;
            // Issue the next read only when its data is sure to fit.
            S_WAIT:  if (occ_after_pop < DEPTH_C) state_nx = S_REQ;
            S_DRAIN: if (pop && pix_last) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= S_IDLE;
            req_cnt    <= '0;
            out_cnt    <= '0;
            SD_address <= BASE_ADDR;
            overrun    <= 1'b0;
        end else begin
            state <= state_nx;
            if (frame_ready) begin
                if (state == S_IDLE) begin
                    req_cnt    <= '0;
                    out_cnt    <= '0;
                    overrun    <= 1'b0;
                    SD_address <= BASE_ADDR;
                end else begin
                    overrun <= 1'b1;
                end
            end
            if (push) begin
                SD_address <= SD_address + STEP;
                if (req_cnt != LAST_IDX) req_cnt <= req_cnt + CW'(1);
            end
            if (pop) out_cnt <= out_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= SD_rdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW + 1)'(1);
                2'b01:   count <= count - (PW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_frame_scanout_reader.sv
// ============================================================================
// tb_frame_scanout_reader
//   Directed bench with an SD_RAM responder model and a pixel-stream checker.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_frame_scanout_reader;

    localparam logic [31:0] BASE = 32'h0;
    localparam int          NPIX = 256;
    localparam int          LAT  = 2;

    logic        clk;
    logic        n_rst;
    logic        frame_ready;
    logic        SD_read;
    logic [31:0] SD_address;
    logic [15:0] SD_rdata;
    logic        SD_rvalid;
    logic [7:0]  pix_r;
    logic [7:0]  pix_g;
    logic [7:0]  pix_b;
    logic        pix_valid;
    logic        pix_ready;
    logic        pix_last;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int n_chk = 0;
    int n_fail = 0;
    int exp_idx = 0;
    int resp_cnt = 0;
    int cyc = 0;
    int last_pop_cyc = 0;
    bit mon_en = 0;

    frame_scanout_reader #(
        .BASE_ADDR (BASE),
        .ADDR_STEP (2),
        .NUM_PIXELS(NPIX),
        .FIFO_DEPTH(4)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .frame_ready(frame_ready),
        .SD_read    (SD_read),
        .SD_address (SD_address),
        .SD_rdata   (SD_rdata),
        .SD_rvalid  (SD_rvalid),
        .pix_r      (pix_r),
        .pix_g      (pix_g),
        .pix_b      (pix_b),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_last   (pix_last),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Frame contents: two hand-picked words at the start, a pattern afterwards.
    function automatic logic [15:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 16'hF81F;
        if (a == 32'h2) return 16'h0841;
        return {a[8:1], a[8:1] ^ 8'h5A};
    endfunction

    function automatic logic [24:0] exp_pix(input int idx);
        logic [15:0] d;
        d = mem_word(BASE + 32'(2 * idx));
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2], (idx == NPIX - 1)};
    endfunction

    // SD_RAM responder: returns data LAT cycles after SD_read is seen.
    initial begin
        int wc;
        wc = 0;
        SD_rvalid = 1'b0;
        SD_rdata  = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            SD_rvalid = 1'b0;
            if (n_rst && SD_read) begin
                if (wc == LAT) begin
                    chk($sformatf("req_addr%0d", resp_cnt), SD_address, BASE + 32'(2 * resp_cnt));
                    SD_rdata  = mem_word(SD_address);
                    SD_rvalid = 1'b1;
                    resp_cnt++;
                    wc = 0;
                end else begin
                    wc++;
                end
            end else begin
                wc = 0;
            end
        end
    end

    // Pixel checker: every accepted pixel must be the next one in address order.
    initial forever begin
        @(negedge clk);
        if (mon_en && pix_valid && pix_ready) begin
            chk($sformatf("pix%0d", exp_idx), {pix_r, pix_g, pix_b, pix_last}, exp_pix(exp_idx));
            last_pop_cyc = cyc;
            exp_idx++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_frame();
        @(posedge clk); #1;
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        chk($sformatf("%s_done_seen", tag), 64'(seen), 64'd1);
        if (seen) chk($sformatf("%s_done_lat", tag), 64'(cyc - last_pop_cyc), 64'd1);
        chk($sformatf("%s_npix", tag), 64'(exp_idx), 64'(NPIX));
        @(negedge clk);
        chk($sformatf("%s_idle", tag), {frame_done, busy}, 2'b00);
    endtask

    initial begin
        logic [24:0] held;
        bit          changed;
        bit          hit;

        n_rst       = 1'b0;
        frame_ready = 1'b0;
        pix_ready   = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sd_read", SD_read, 1'b0);
        chk("rst_addr", SD_address, BASE);
        chk("rst_pix", {pix_valid, pix_last, pix_r, pix_g, pix_b}, 26'h0);
        chk("rst_flags", {busy, frame_done, overrun}, 3'b000);
        @(posedge clk); #1;
        n_rst = 1'b1;
        @(negedge clk);
        chk("idle_busy", {busy, SD_read}, 2'b00);

        // Full frame with pix_ready high, latency and expansion checks
        pix_ready = 1'b1;
        exp_idx   = 0;
        resp_cnt  = 0;
        mon_en    = 1'b1;
        start_frame();
        @(negedge clk);
        chk("lat_sd_read", {SD_read, busy}, 2'b11);
        chk("lat_addr0", SD_address, BASE);
        @(negedge clk);
        @(negedge clk);
        chk("lat_rvalid_novalid", {SD_rvalid, pix_valid}, 2'b10);
        @(negedge clk);
        chk("lat_pix_valid", {pix_valid, SD_read}, 2'b10);
        chk("addr_after_push", SD_address, BASE + 32'd2);
        chk("expand_F81F", {pix_r, pix_g, pix_b}, 24'hFF00FF);
        repeat (4) @(negedge clk);
        chk("expand_0841_valid", pix_valid, 1'b1);
        chk("expand_0841", {pix_r, pix_g, pix_b}, 24'h080808);
        wait_done("full");

        // Backpressure: FIFO fills with four words, then requests stop
        exp_idx   = 0;
        resp_cnt  = 0;
        pix_ready = 1'b0;
        start_frame();
        changed = 1'b0;
        held    = '0;
        hit     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pix_valid) begin
                if (!hit) begin
                    held = {pix_r, pix_g, pix_b, pix_last};
                    hit  = 1'b1;
                end else if ({pix_r, pix_g, pix_b, pix_last} !== held) begin
                    changed = 1'b1;
                end
            end
        end
        chk("bp_reqs", 64'(resp_cnt), 64'd4);
        chk("bp_sd_read", SD_read, 1'b0);
        chk("bp_valid", pix_valid, 1'b1);
        chk("bp_stable", 64'(changed), 64'd0);
        chk("bp_head", {pix_r, pix_g, pix_b, pix_last}, exp_pix(0));
        @(posedge clk); #1;
        pix_ready = 1'b1;
        wait_done("bp");

        // frame_ready while busy: ignored, overrun is sticky
        exp_idx  = 0;
        resp_cnt = 0;
        start_frame();
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge clk);
            if (exp_idx >= 100) hit = 1'b1;
        end
        chk("ovr_reach100", 64'(hit), 64'd1);
        @(posedge clk); #1;
        frame_ready = 1'b1;
        @(posedge clk); #1;
        frame_ready = 1'b0;
        @(negedge clk);
        chk("ovr_set", {overrun, busy}, 2'b11);
        wait_done("ovr");
        chk("ovr_sticky", overrun, 1'b1);
        pix_ready = 1'b0;
        exp_idx   = 0;
        resp_cnt  = 0;
        start_frame();
        @(negedge clk);
        chk("ovr_clear", overrun, 1'b0);
        chk("restart_addr", {SD_read, SD_address}, {1'b1, BASE});

        // Asynchronous reset with a request pending and three pixels buffered
        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (resp_cnt == 3 && SD_read) hit = 1'b1;
        end
        chk("arst_setup", {64'(hit)}, 64'd1);
        chk("arst_pre", {pix_valid, busy}, 2'b11);
        #2;
        n_rst = 1'b0;
        #1;
        chk("arst_drop", {SD_read, pix_valid, busy}, 3'b000);
        @(posedge clk); #1;
        n_rst     = 1'b1;
        exp_idx   = 0;
        resp_cnt  = 0;
        pix_ready = 1'b1;
        start_frame();
        @(negedge clk);
        chk("arst_restart", {SD_read, SD_address}, {1'b1, BASE});
        wait_done("arst");

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
